i2c_target_regs: RTL
====================

Name: i2c_target_regs

Overview:
I2C target (slave) that sits on the sda/scl bus driven by the i2c_top master and consumes its transactions. It exposes a small register file: the master writes a register pointer and data bytes, and reads bytes back. Bus lines are oversampled on the fabric clock; the block never drives scl (no clock stretching). A local fabric-side port lets other logic read registers and observe write events.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address that is matched.
- NUM_REGS, 16, register count; power of two, 2..256.
- PTR_W, 4, pointer width; equals log2(NUM_REGS).

Ports:
- clk  input  1  fabric clock (FAB_CCC_GL0 domain); at least 8x the SCL rate.
- rst  input  1  synchronous, active-high reset.
- scl_in  input  1  sampled SCL line (asynchronous).
- sda_in  input  1  sampled SDA line (asynchronous).
- sda_oe  output  1  1 = pull SDA low; the top level builds an open-drain pad from it.
- loc_addr  input  PTR_W  fabric-side register read address.
- loc_rdata  output  8  combinational read of regs[loc_addr].
- wr_stb  output  1  one-cycle pulse when the master writes a register.
- wr_addr  output  PTR_W  register index written; valid with wr_stb.
- wr_data  output  8  byte written; valid with wr_stb.
- busy  output  1  high from an address-matched START until STOP or NACK release.

Behaviour:
- Sync: scl_in and sda_in each pass through 2 flops; edges are detected on the synchronized values (previous vs current).
- START: sda falls while scl=1. STOP: sda rises while scl=1. Both are detected in every state and have priority over bit processing.
- Bit sampling: sda is sampled on the synchronized scl rising edge. sda_oe may change only on the synchronized scl falling edge, plus one clk cycle (hold margin).
- States:
  - IDLE
  - ADDR: shift in 8 bits, MSB first.
  - ADDR_ACK
  - PTR: shift in 8 bits.
  - PTR_ACK
  - WDATA
  - WDATA_ACK
  - RDATA: shift out 8 bits.
  - RD_ACK: sample the master's ACK/NACK.
  - IGNORE
- IDLE/any + START -> ADDR, bit counter cleared. Repeated START behaves identically.
- ADDR after 8 bits:
  - addr[7:1]==DEV_ADDR -> ADDR_ACK: drive sda_oe=1 for the 9th SCL period; busy=1.
  - Otherwise -> IGNORE: sda_oe stays 0 until the next START or STOP.
- ADDR_ACK, rw=0 -> PTR. rw=1 -> RDATA; load shift register with regs[ptr] at the ACK-period scl fall.
- PTR: byte[PTR_W-1:0] loads ptr; upper bits are ignored. ACK, then -> WDATA.
- WDATA: 8 bits -> regs[ptr] <= byte. wr_stb pulses 1 cycle with wr_addr=ptr (pre-increment) and wr_data=byte. ACK, then ptr <= ptr+1 mod NUM_REGS; stay in WDATA loop.
- RDATA: drive sda_oe = ~shift[7] on each scl fall; 8 bits; release at the 8th bit fall -> RD_ACK.
  - Master ACK (sda=0): ptr <= ptr+1 mod NUM_REGS, load next byte, -> RDATA.
  - Master NACK: -> IGNORE, busy=0.
- Pointer wrap: ptr 15 + 1 -> 0 (NUM_REGS=16), for both reads and writes.
- STOP in any state -> IDLE, sda_oe=0, busy=0. ptr is retained across transactions. A partially received byte is discarded and does not reach regs.
- Register write and a simultaneous loc_addr read of the same index: loc_rdata shows the old value that cycle and the new value the next cycle.
- Reset values (all outputs and state):
  - state=IDLE, sda_oe=0, busy=0, wr_stb=0, wr_addr=0, wr_data=0, ptr=0.
  - All regs=8'h00.
  - Sync flops reset to 1 (idle bus).
- Reset mid-transaction: sda_oe is released in the next cycle. The block then waits for a fresh START; the remaining bits of the in-flight transfer are ignored.

Optional Feature:
- Macro I2C_SPIKE_FILTER_EN.
- Defined: after the 2-flop sync, each line passes a 3-sample majority filter. Pulses of 1 clk are rejected. Edge detection gains 2 clk latency. Filter flops reset to 1.
- Undefined: synchronized values are used directly; no added latency; a 1-clk glitch is seen as an edge.

Test Plan:
- Write: S, 0xA0, 0x03, 0x5A, 0xC3, P -> ACK on all 4 bytes; regs[3]=0x5A, regs[4]=0xC3; wr_stb pulses twice with (3,0x5A) then (4,0xC3); busy falls at STOP.
- Read with repeated START: after the write above, S, 0xA0, 0x03, Sr, 0xA1, read 2 bytes (ACK, NACK), P -> SDA carries 0x5A then 0xC3; sda_oe=0 after the NACK.
- Address miss: S, 0xA2, 0x00, P -> no ACK (sda_oe never 1); busy=0; regs unchanged; wr_stb never pulses.
- Wrap: S, 0xA0, 0x0F, 0x11, 0x22, P -> regs[15]=0x11, regs[0]=0x22; ptr=1 afterwards.
- Abort: rst asserted for 1 clk during the ADDR_ACK low phase -> sda_oe=0 the next cycle. Following S, 0xA0, 0x00, 0x77, P -> regs[0]=0x77, ACKs correct.
- Glitch (macro defined): 1-clk low pulse on scl_in while sda=1 mid-byte -> no bit shifted, byte completes correctly. With the macro undefined, the same stimulus corrupts the byte (regression expectation).

Source files
------------

// File: rtl/i2c_target_regs.sv
// ---------------------------------------------------------------------------
// i2c_target_regs
//
// I2C target with a small register file. The master addresses the target,
// writes a register pointer, then writes data bytes (auto-incrementing
// pointer) or issues a repeated START and reads bytes back (auto-incrementing
// on each master ACK). SCL and SDA are oversampled on clk; the target never
// drives SCL.
//
// Optional build macro:
//   I2C_SPIKE_FILTER_EN - adds a 3-sample majority filter behind the 2-flop
//                         synchronizers; rejects 1-clk pulses and adds 2 clk
//                         of edge latency.
//
// Ports:
//   clk        fabric clock, at least 8x the SCL rate
//   rst        synchronous active-high reset
//   scl_in     raw SCL line (asynchronous)
//   sda_in     raw SDA line (asynchronous)
//   sda_oe     1 = pull SDA low (open-drain pad built at the top level)
//   loc_addr   fabric-side register read index
//   loc_rdata  combinational regs[loc_addr]
//   wr_stb     one-cycle pulse when the master writes a register
//   wr_addr    register index written, valid with wr_stb
//   wr_data    byte written, valid with wr_stb
//   busy       high from an address-matched START until STOP or read NACK
//
// wr_stb is a bare strobe: no back-pressure, wr_addr/wr_data are only
// meaningful in the cycle wr_stb is high and hold their value otherwise.
// ---------------------------------------------------------------------------
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         NUM_REGS = 16,
  parameter int         PTR_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] loc_addr,
  output logic [7:0]       loc_rdata,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [7:0]       shift;
  logic [PTR_W-1:0] ptr;
  logic             rw;
  logic             ack_clk;   // the 9th (ACK) SCL rise has been seen
  logic             fall_d;    // scl fall delayed one clk: sda_oe update slot
  logic [7:0]       regs [NUM_REGS];

  // ---------------------------------------------------------------------
  // Line conditioning
  // ---------------------------------------------------------------------
  logic scl_s1, scl_s2, sda_s1, sda_s2;
  logic scl_cur, sda_cur, scl_prev, sda_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
    end
  end

`ifdef I2C_SPIKE_FILTER_EN
  logic [2:0] scl_f, sda_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_f <= 3'b111;
      sda_f <= 3'b111;
    end else begin
      scl_f <= {scl_f[1:0], scl_s2};
      sda_f <= {sda_f[1:0], sda_s2};
    end
  end

  // Two of three agreeing samples: a single-cycle pulse never wins.
  assign scl_cur = (scl_f[0] & scl_f[1]) | (scl_f[0] & scl_f[2]) | (scl_f[1] & scl_f[2]);
  assign sda_cur = (sda_f[0] & sda_f[1]) | (sda_f[0] & sda_f[2]) | (sda_f[1] & sda_f[2]);
`else
  assign scl_cur = scl_s2;
  assign sda_cur = sda_s2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_cur;
      sda_prev <= sda_cur;
    end
  end

  logic scl_rise, scl_fall, start_cond, stop_cond;

  assign scl_rise = scl_cur & ~scl_prev;
  assign scl_fall = ~scl_cur & scl_prev;
  // SCL must be high on both samples so a data change racing an SCL fall
  // through the synchronizers is not mistaken for START/STOP.
  assign start_cond = ~sda_cur & sda_prev & scl_cur & scl_prev;
  assign stop_cond  = sda_cur & ~sda_prev & scl_cur & scl_prev;

  // ---------------------------------------------------------------------
  // Protocol engine
  // ---------------------------------------------------------------------
  logic [7:0]       rx_byte;
  logic [PTR_W-1:0] ptr_nxt;

  assign rx_byte = {shift[6:0], sda_cur};
  assign ptr_nxt = ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      shift   <= 8'h00;
      ptr     <= '0;
      rw      <= 1'b0;
      ack_clk <= 1'b0;
      fall_d  <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      wr_stb <= 1'b0;
      fall_d <= scl_fall;
      if (start_cond) begin
        state   <= S_ADDR;
        cnt     <= 4'd0;
        ack_clk <= 1'b0;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
      end else if (stop_cond) begin
        // Any partially shifted byte is simply dropped here.
        state   <= S_IDLE;
        cnt     <= 4'd0;
        ack_clk <= 1'b0;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
      end else begin
        // Bit sampling on SCL rise.
        if (scl_rise) begin
          case (state)
            S_ADDR: begin
              shift <= rx_byte;
              cnt   <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                ack_clk <= 1'b0;
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state <= S_ADDR_ACK;
                  rw    <= rx_byte[0];
                  busy  <= 1'b1;
                end else begin
                  state <= S_IGNORE;
                end
              end
            end
            S_PTR: begin
              shift <= rx_byte;
              cnt   <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                ptr     <= rx_byte[PTR_W-1:0];
                ack_clk <= 1'b0;
                state   <= S_PTR_ACK;
              end
            end
            S_WDATA: begin
              shift <= rx_byte;
              cnt   <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                regs[ptr] <= rx_byte;
                wr_stb    <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= rx_byte;
                ack_clk   <= 1'b0;
                state     <= S_WDATA_ACK;
              end
            end
            S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: ack_clk <= 1'b1;
            S_RDATA: cnt <= cnt + 4'd1;
            S_RD_ACK: begin
              if (!sda_cur) begin
                // Master ACK: prefetch the next byte before the SCL fall.
                ack_clk <= 1'b1;
                ptr     <= ptr_nxt;
                shift   <= regs[ptr_nxt];
              end else begin
                state <= S_IGNORE;
                busy  <= 1'b0;
              end
            end
            default: ;
          endcase
        end

        // Phase changes on SCL fall (only after the ACK clock has run).
        if (scl_fall) begin
          case (state)
            S_ADDR_ACK: begin
              if (ack_clk) begin
                ack_clk <= 1'b0;
                cnt     <= 4'd0;
                if (rw) begin
                  state <= S_RDATA;
                  shift <= regs[ptr];
                end else begin
                  state <= S_PTR;
                end
              end
            end
            S_PTR_ACK: begin
              if (ack_clk) begin
                ack_clk <= 1'b0;
                cnt     <= 4'd0;
                state   <= S_WDATA;
              end
            end
            S_WDATA_ACK: begin
              if (ack_clk) begin
                ack_clk <= 1'b0;
                cnt     <= 4'd0;
                ptr     <= ptr_nxt;
                state   <= S_WDATA;
              end
            end
            S_RDATA: begin
              if (cnt == 4'd8) state <= S_RD_ACK;
              else shift <= {shift[6:0], 1'b0};
            end
            S_RD_ACK: begin
              if (ack_clk) begin
                ack_clk <= 1'b0;
                cnt     <= 4'd0;
                state   <= S_RDATA;
              end
            end
            default: ;
          endcase
        end

        // SDA drive changes one clk after the SCL fall, reflecting the
        // state chosen at that fall.
        if (fall_d) begin
          case (state)
            S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: sda_oe <= 1'b1;
            S_RDATA: sda_oe <= ~shift[7];
            default: sda_oe <= 1'b0;
          endcase
        end
      end
    end
  end

  assign loc_rdata = regs[loc_addr];

endmodule
